mux_sel_arbiter: RTL and testbench



---
 rtl/mux_sel_arbiter_if.sv | 24 ++
 rtl/mux_sel_arbiter.sv | 113 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between requesters and the shared-mux arbiter.
// Requesters drive req/rel; the arbiter returns grant, select and status.
interface mux_sel_arbiter_if #(
  parameter int S_LINES = 2
);
  localparam int N = 1 << S_LINES;

  logic [N-1:0]       req;
  logic               rel;
  logic [N-1:0]       gnt;
  logic [S_LINES-1:0] sel;
  logic               busy;
  logic               timeout;

  modport master (
    output req, rel,
    input  gnt, sel, busy, timeout
  );

  modport slave (
    input  req, rel,
    output gnt, sel, busy, timeout
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbitration for one shared datapath mux.
// A grant is held until release, request drop or hold limit; a GAP cycle separates owners.
module mux_sel_arbiter #(
  parameter int S_LINES  = 2,
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  mux_sel_arbiter_if.slave  bus
);
  localparam int N = 1 << S_LINES;

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;

  typedef struct packed {
    logic [N-1:0]       gnt;
    logic [S_LINES-1:0] sel;
    logic               busy;
    logic               timeout;
  } out_t;

  state_e             state_q, state_d;
  out_t               out_q, out_d;
  logic [S_LINES-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               win_vld;
  logic [S_LINES-1:0] win_idx;
  logic               own_rel;
  logic               own_to;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    logic [S_LINES-1:0] idx;
    idx     = '0;
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_q + S_LINES'(i);
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  assign own_rel = !bus.req[out_q.sel] || bus.rel;
  assign own_to  = (hold_q == HOLD_W'(MAX_HOLD));

  always_comb begin
    state_d         = state_q;
    out_d           = out_q;
    out_d.timeout   = 1'b0;
    ptr_d           = ptr_q;
    hold_d          = hold_q;
    case (state_q)
      IDLE, GAP: begin
        if (win_vld) begin
          state_d            = OWN;
          out_d.gnt          = '0;
          out_d.gnt[win_idx] = 1'b1;
          out_d.sel          = win_idx;
          out_d.busy         = 1'b1;
          hold_d             = HOLD_W'(1);
          ptr_d              = win_idx + S_LINES'(1);
        end else begin
          state_d    = IDLE;
          out_d.gnt  = '0;
          out_d.busy = 1'b0;
          hold_d     = '0;
        end
      end
      OWN: begin
        if (own_rel || own_to) begin
          // A normal release outranks the limit, so no timeout pulse then.
          state_d       = GAP;
          out_d.gnt     = '0;
          out_d.busy    = 1'b0;
          out_d.timeout = !own_rel;
          hold_d        = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        out_d.gnt  = '0;
        out_d.busy = 1'b0;
        hold_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.gnt     = out_q.gnt;
  assign bus.sel     = out_q.sel;
  assign bus.busy    = out_q.busy;
  assign bus.timeout = out_q.timeout;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: vector table plus hand sequences for hold limit and async reset.
module tb_mux_sel_arbiter;
  localparam int S_LINES  = 2;
  localparam int MAX_HOLD = 15;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic       rel;
    exp_t       e;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  mux_sel_arbiter_if #(.S_LINES(S_LINES)) intf ();

  mux_sel_arbiter #(
    .S_LINES (S_LINES),
    .MAX_HOLD(MAX_HOLD),
    .HOLD_W  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(intf)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s, input logic b, input logic t);
    exp_t e;
    e.gnt  = g;
    e.sel  = s;
    e.busy = b;
    e.to   = t;
    return e;
  endfunction

  task automatic check_out(input string name);
    exp_t exp;
    exp_t got;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, no expected value queued", name);
      return;
    end
    exp = sb.pop_front();
    got = {intf.gnt, intf.sel, intf.busy, intf.timeout};
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
               name, got.gnt, got.sel, got.busy, got.to, exp.gnt, exp.sel, exp.busy, exp.to);
    end
  endtask

  task automatic apply(input string name, input logic [3:0] r, input logic l, input exp_t e);
    intf.req = r;
    intf.rel = l;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(name);
  endtask

  vec_t tbl[23];

  initial begin
    checks   = 0;
    errors   = 0;
    clk      = 1'b0;
    rst      = 1'b1;
    intf.req = '0;
    intf.rel = 1'b0;

    // Round robin with req=1111, then pointer skip with req=1001, then drop/idle cases.
    tbl[0]  = '{4'b1111, 1'b0, mk(4'b0001, 2'd0, 1'b1, 1'b0)};
    tbl[1]  = '{4'b1111, 1'b1, mk(4'b0000, 2'd0, 1'b0, 1'b0)};
    tbl[2]  = '{4'b1111, 1'b0, mk(4'b0010, 2'd1, 1'b1, 1'b0)};
    tbl[3]  = '{4'b1111, 1'b1, mk(4'b0000, 2'd1, 1'b0, 1'b0)};
    tbl[4]  = '{4'b1111, 1'b0, mk(4'b0100, 2'd2, 1'b1, 1'b0)};
    tbl[5]  = '{4'b1111, 1'b1, mk(4'b0000, 2'd2, 1'b0, 1'b0)};
    tbl[6]  = '{4'b1111, 1'b0, mk(4'b1000, 2'd3, 1'b1, 1'b0)};
    tbl[7]  = '{4'b1111, 1'b1, mk(4'b0000, 2'd3, 1'b0, 1'b0)};
    tbl[8]  = '{4'b1111, 1'b0, mk(4'b0001, 2'd0, 1'b1, 1'b0)};
    tbl[9]  = '{4'b1111, 1'b1, mk(4'b0000, 2'd0, 1'b0, 1'b0)};
    tbl[10] = '{4'b1001, 1'b0, mk(4'b1000, 2'd3, 1'b1, 1'b0)};
    tbl[11] = '{4'b1001, 1'b1, mk(4'b0000, 2'd3, 1'b0, 1'b0)};
    tbl[12] = '{4'b1001, 1'b0, mk(4'b0001, 2'd0, 1'b1, 1'b0)};
    tbl[13] = '{4'b1001, 1'b1, mk(4'b0000, 2'd0, 1'b0, 1'b0)};
    tbl[14] = '{4'b1001, 1'b0, mk(4'b1000, 2'd3, 1'b1, 1'b0)};
    tbl[15] = '{4'b0000, 1'b0, mk(4'b0000, 2'd3, 1'b0, 1'b0)};
    tbl[16] = '{4'b0000, 1'b0, mk(4'b0000, 2'd3, 1'b0, 1'b0)};
    tbl[17] = '{4'b0000, 1'b1, mk(4'b0000, 2'd3, 1'b0, 1'b0)};
    tbl[18] = '{4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b1, 1'b0)};
    tbl[19] = '{4'b0110, 1'b0, mk(4'b0100, 2'd2, 1'b1, 1'b0)};
    tbl[20] = '{4'b0010, 1'b0, mk(4'b0000, 2'd2, 1'b0, 1'b0)};
    tbl[21] = '{4'b0000, 1'b1, mk(4'b0000, 2'd2, 1'b0, 1'b0)};
    tbl[22] = '{4'b0000, 1'b1, mk(4'b0000, 2'd2, 1'b0, 1'b0)};

    #12;
    sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
    check_out("reset_state");
    rst = 1'b0;

    foreach (tbl[i])
      apply($sformatf("vec[%0d]", i), tbl[i].req, tbl[i].rel, tbl[i].e);

    // Sole requester 1 held: 15 owned cycles, one GAP with timeout, then re-grant.
    for (int i = 0; i < MAX_HOLD; i++)
      apply($sformatf("hold[%0d]", i), 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b1, 1'b0));
    apply("timeout_gap", 4'b0010, 1'b0, mk(4'b0000, 2'd1, 1'b0, 1'b1));
    apply("timeout_regrant", 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b1, 1'b0));

    // Drop the request on the hold==MAX_HOLD cycle: normal release, no timeout.
    for (int i = 1; i < MAX_HOLD; i++)
      apply($sformatf("hold2[%0d]", i), 4'b0010, 1'b0, mk(4'b0010, 2'd1, 1'b1, 1'b0));
    apply("coincident_gap", 4'b0000, 1'b0, mk(4'b0000, 2'd1, 1'b0, 1'b0));
    apply("coincident_idle", 4'b0000, 1'b0, mk(4'b0000, 2'd1, 1'b0, 1'b0));

    // Asynchronous reset in the middle of a grant to requester 2.
    apply("pre_reset_grant", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b1, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
    check_out("async_reset");
    #1;
    rst = 1'b0;
    apply("post_reset_grant", 4'b0100, 1'b0, mk(4'b0100, 2'd2, 1'b1, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
